midi_note_decoder: RTL and testbench

//  Parses a received MIDI byte stream (from the UART receiver) into single-cycle

---
 rtl/midi_pkg.sv | 25 ++
 rtl/midi_note_decoder_if.sv | 22 ++
 rtl/midi_note_decoder.sv | 146 ++++++++++++++
 tb/tb_midi_note_decoder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI decoder definitions: status nibbles, parser state encoding and
// the data-byte count for each channel-voice message type.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CHPRESS  = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_D1   = 2'd1,
        S_D2   = 2'd2
    } state_e;

    // Program change and channel pressure carry one data byte; all others two.
    function automatic logic [1:0] midi_data_len(input logic [3:0] nibble);
        if (nibble == ST_PROG || nibble == ST_CHPRESS) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

endpackage

// File: rtl/midi_note_decoder_if.sv
// Byte-stream input and note-event output bundle of the MIDI note decoder.
// Handshake: byte_in is consumed on every clk edge where byte_rdy=1 (no backpressure); note_on/note_off/all_off are single-cycle strobes, note/velocity are level outputs.
interface midi_note_decoder_if;
    logic       byte_rdy;
    logic [7:0] byte_in;
    logic [3:0] ch_sel;
    logic       note_on;
    logic       note_off;
    logic [6:0] note;
    logic [6:0] velocity;
    logic       all_off;

    modport master (
        output byte_rdy, byte_in, ch_sel,
        input  note_on, note_off, note, velocity, all_off
    );

    modport slave (
        input  byte_rdy, byte_in, ch_sel,
        output note_on, note_off, note, velocity, all_off
    );
endinterface

// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser producing note_on/note_off/all_off strobes with note and velocity.
// Optional macro MIDI_CH_FILTER_EN: accept only messages on channel ch_sel (omni otherwise).
module midi_note_decoder
    import midi_pkg::*;
#(
    parameter logic [6:0] CC_ALL_OFF = 7'd123
) (
    input  logic                 clk,
    input  logic                 rst,
    midi_note_decoder_if.slave   bus,
    output state_e               state_o
);

    state_e     state_q, state_d;
    logic [3:0] st_type_q, st_type_d;
    logic [3:0] st_chan_q, st_chan_d;
    logic [6:0] d1_q, d1_d;
    logic [6:0] note_q, note_d;
    logic [6:0] vel_q, vel_d;
    logic       note_on_q, note_on_d;
    logic       note_off_q, note_off_d;
    logic       all_off_q, all_off_d;

    logic       done;
    logic [6:0] msg_d1;
    logic [6:0] msg_d2;
    logic       ch_match;
    logic       is_realtime;

`ifdef MIDI_CH_FILTER_EN
    assign ch_match = (st_chan_q == bus.ch_sel);
`else
    logic unused_ch;
    assign ch_match  = 1'b1;
    assign unused_ch = ^{bus.ch_sel, st_chan_q};
`endif

    assign is_realtime = (bus.byte_in >= 8'hF8);

    always_comb begin
        state_d    = state_q;
        st_type_d  = st_type_q;
        st_chan_d  = st_chan_q;
        d1_d       = d1_q;
        note_d     = note_q;
        vel_d      = vel_q;
        note_on_d  = 1'b0;
        note_off_d = 1'b0;
        all_off_d  = 1'b0;
        done       = 1'b0;
        msg_d1     = 7'd0;
        msg_d2     = 7'd0;

        if (bus.byte_rdy && !is_realtime) begin
            if (bus.byte_in[7]) begin
                // A new status always restarts framing, dropping any partial message.
                if (bus.byte_in < 8'hF0) begin
                    st_type_d = bus.byte_in[7:4];
                    st_chan_d = bus.byte_in[3:0];
                    state_d   = S_D1;
                end else begin
                    st_type_d = 4'd0;
                    st_chan_d = 4'd0;
                    state_d   = S_IDLE;
                end
            end else begin
                case (state_q)
                    S_D1: begin
                        d1_d = bus.byte_in[6:0];
                        if (midi_data_len(st_type_q) == 2'd1) begin
                            done   = 1'b1;
                            msg_d1 = bus.byte_in[6:0];
                        end else begin
                            state_d = S_D2;
                        end
                    end
                    S_D2: begin
                        done    = 1'b1;
                        msg_d1  = d1_q;
                        msg_d2  = bus.byte_in[6:0];
                        state_d = S_D1;
                    end
                    default: state_d = state_q;
                endcase
            end
        end

        if (done && ch_match) begin
            case (st_type_q)
                ST_NOTE_ON: begin
                    note_d = msg_d1;
                    if (msg_d2 != 7'd0) begin
                        note_on_d = 1'b1;
                        vel_d     = msg_d2;
                    end else begin
                        note_off_d = 1'b1;
                        vel_d      = 7'd0;
                    end
                end
                ST_NOTE_OFF: begin
                    note_off_d = 1'b1;
                    note_d     = msg_d1;
                    vel_d      = msg_d2;
                end
                ST_CC: begin
                    if (msg_d1 == CC_ALL_OFF) begin
                        all_off_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            st_type_q  <= 4'd0;
            st_chan_q  <= 4'd0;
            d1_q       <= 7'd0;
            note_q     <= 7'd0;
            vel_q      <= 7'd0;
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            all_off_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_type_q  <= st_type_d;
            st_chan_q  <= st_chan_d;
            d1_q       <= d1_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
            all_off_q  <= all_off_d;
        end
    end

    assign bus.note_on  = note_on_q;
    assign bus.note_off = note_off_q;
    assign bus.all_off  = all_off_q;
    assign bus.note     = note_q;
    assign bus.velocity = vel_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed bench for midi_note_decoder: expected note events are queued as
// bytes are sent and a monitor pops and compares each strobe the DUT emits.
module tb_midi_note_decoder;
    import midi_pkg::*;

    localparam logic [1:0] EV_ON  = 2'd1;
    localparam logic [1:0] EV_OFF = 2'd2;
    localparam logic [1:0] EV_ALL = 2'd3;

    logic   clk;
    logic   rst;
    state_e state_o;

    midi_note_decoder_if bus ();

    midi_note_decoder dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    int total;
    int bad;
    logic [15:0] exp_q[$];
    logic [6:0]  last_note;
    logic [6:0]  last_vel;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.byte_rdy = 1'b0;
        bus.byte_in  = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.byte_rdy = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_note = 7'd0;
        last_vel  = 7'd0;
    endtask

    // Keeps byte_rdy high so consecutive calls deliver bytes on back-to-back cycles.
    task automatic send(input logic [7:0] b);
        bus.byte_rdy = 1'b1;
        bus.byte_in  = b;
        @(negedge clk);
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [6:0] n, input logic [6:0] v);
        if (kind != EV_ALL) begin
            last_note = n;
            last_vel  = v;
        end
        exp_q.push_back({kind, last_note, last_vel});
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [1:0]  kind;
        logic [15:0] exp;
        if (!rst && (bus.note_on || bus.note_off || bus.all_off)) begin
            kind = bus.note_on ? EV_ON : (bus.note_off ? EV_OFF : EV_ALL);
            check("one_strobe", int'(bus.note_on) + int'(bus.note_off) + int'(bus.all_off), 1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got kind=%0d note=%0d vel=%0d expected none",
                         kind, bus.note, bus.velocity);
            end else begin
                exp = exp_q.pop_front();
                check("event_kind", int'(kind), int'(exp[15:14]));
                check("event_note", int'(bus.note), int'(exp[13:7]));
                check("event_vel", int'(bus.velocity), int'(exp[6:0]));
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.byte_rdy = 1'b0;
        bus.byte_in  = 8'h00;
        bus.ch_sel   = 4'd2;
        last_note = 7'd0;
        last_vel  = 7'd0;
        @(negedge clk);
        // rst dominates a simultaneous byte
        bus.byte_rdy = 1'b1;
        bus.byte_in  = 8'h90;
        @(negedge clk);
        do_reset();

        check("rst_note_on", int'(bus.note_on), 0);
        check("rst_note_off", int'(bus.note_off), 0);
        check("rst_all_off", int'(bus.all_off), 0);
        check("rst_note", int'(bus.note), 0);
        check("rst_velocity", int'(bus.velocity), 0);
        check("rst_state", int'(state_o), int'(S_IDLE));

        // 1: note on, then running status with gaps between bytes
        send(8'h90); idle(1);
        send(8'h3C); idle(2);
        expect_ev(EV_ON, 7'd60, 7'd100);
        send(8'h64); idle(1);
        send(8'h3E);
        expect_ev(EV_ON, 7'd62, 7'd80);
        send(8'h50); idle(3);
        check("state_after_rs", int'(state_o), int'(S_D1));

        // 2: velocity-0 note-on and explicit note-off, back to back
        send(8'h90); send(8'h3C);
        expect_ev(EV_OFF, 7'd60, 7'd0);
        send(8'h00);
        send(8'h80); send(8'h40);
        expect_ev(EV_OFF, 7'd64, 7'd127);
        send(8'h7F); idle(3);

        // 3: realtime bytes interleaved
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE);
        expect_ev(EV_ON, 7'd60, 7'd100);
        send(8'h64); idle(3);

        // 4: aborted message, then system-common status drops data
        send(8'h90); send(8'h3C); send(8'h90); send(8'h3E);
        expect_ev(EV_ON, 7'd62, 7'd64);
        send(8'h40);
        send(8'hF0); send(8'h3C); send(8'h64); idle(2);
        check("state_after_f0", int'(state_o), int'(S_IDLE));

        // 5: all-notes-off, other CC, program change then note on
        send(8'hB0); send(8'h7B);
        expect_ev(EV_ALL, 7'd0, 7'd0);
        send(8'h00);
        send(8'hB0); send(8'h07); send(8'h64);
        send(8'hC0); send(8'h05);
        send(8'h90); send(8'h3C);
        expect_ev(EV_ON, 7'd60, 7'd100);
        send(8'h64); idle(3);

        // 6: channel filtering (ch_sel=2) and reset mid-message
        send(8'h91); send(8'h3C);
`ifndef MIDI_CH_FILTER_EN
        expect_ev(EV_ON, 7'd60, 7'd100);
`endif
        send(8'h64);
        send(8'h92); send(8'h3C);
        expect_ev(EV_ON, 7'd60, 7'd100);
        send(8'h64); idle(2);
        send(8'h92); idle(1);
        do_reset();
        check("rst_mid_state", int'(state_o), int'(S_IDLE));
        check("rst_mid_note", int'(bus.note), 0);
        send(8'h3C); send(8'h64); idle(4);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
